// File: rtl/sfu_pkg.sv
// Shared types and constants for the sfu_accum accumulation stage.
package sfu_pkg;

  localparam int COL      = 8;
  localparam int PSUM_BW  = 16;
  localparam int DEPTH    = 16;
  localparam int NUM_PASS = 9;
  localparam int AW       = $clog2(DEPTH);
  localparam int PCW      = $clog2(NUM_PASS + 1);

  typedef logic signed [PSUM_BW-1:0] psum_t;

  localparam psum_t PSUM_MAX = psum_t'({1'b0, {(PSUM_BW-1){1'b1}}});
  localparam psum_t PSUM_MIN = psum_t'({1'b1, {(PSUM_BW-1){1'b0}}});

  typedef enum logic [1:0] {IDLE, ACCUM, RELU, DONE} state_t;

  function automatic psum_t relu_clamp(input psum_t v);
    return v[PSUM_BW-1] ? psum_t'(0) : v;
  endfunction

endpackage

// File: rtl/sfu_accum_if.sv
// Psum beat stream into the accumulation stage (valid/ready handshake).
interface sfu_accum_if;
  import sfu_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [AW-1:0]          in_addr;
  logic [COL*PSUM_BW-1:0] in_psum;

  modport master (output in_valid, output in_addr, output in_psum, input in_ready);
  modport slave  (input in_valid, input in_addr, input in_psum, output in_ready);

endinterface

// File: rtl/sfu_lane.sv
// One lane of the accumulator: signed add that clamps instead of wrapping.
module sfu_lane
  import sfu_pkg::*;
(
  input  psum_t acc,
  input  psum_t addend,
  output psum_t sum
);

  logic [PSUM_BW:0] wide;

  // A carry into the extra sign bit that disagrees with the result sign means overflow.
  always_comb begin
    wide = {acc[PSUM_BW-1], acc} + {addend[PSUM_BW-1], addend};
    if (wide[PSUM_BW] != wide[PSUM_BW-1]) begin
      sum = wide[PSUM_BW] ? PSUM_MIN : PSUM_MAX;
    end else begin
      sum = psum_t'(wide[PSUM_BW-1:0]);
    end
  end

endmodule

// File: rtl/sfu_accum.sv
// Lane-wise psum accumulator over NUM_PASS passes into a 16-row bank with readout.
// Define SFU_RELU_EN to insert a one-cycle ReLU pass over the bank before DONE.
module sfu_accum
  import sfu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  sfu_accum_if.slave             in_if,
  output logic                   busy,
  output logic                   done,
  input  logic [AW-1:0]          rd_addr,
  output logic [COL*PSUM_BW-1:0] rd_data,
  output logic [PCW-1:0]         pass_cnt
);

  state_t state;
  state_t next_state;
  psum_t  bank    [DEPTH][COL];
  psum_t  old_row [COL];
  psum_t  sum_row [COL];
  logic   accept;
  logic   pass_end;
  logic   final_beat;

  assign in_if.in_ready = (state == ACCUM) && !start;
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign pass_end       = accept && (in_if.in_addr == AW'(DEPTH - 1));
  assign final_beat     = pass_end && (pass_cnt == PCW'(NUM_PASS - 1));
  assign busy           = (state == ACCUM) || (state == RELU);

  always_comb begin
    for (int l = 0; l < COL; l++) begin
      old_row[l] = bank[in_if.in_addr][l];
    end
  end

  for (genvar l = 0; l < COL; l++) begin : g_lane
    sfu_lane u_lane (
      .acc    (old_row[l]),
      .addend (psum_t'(in_if.in_psum[l*PSUM_BW +: PSUM_BW])),
      .sum    (sum_row[l])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // start overrides everything, including a restart from the middle of ACCUM.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (final_beat) begin
`ifdef SFU_RELU_EN
            next_state = RELU;
`else
            next_state = DONE;
`endif
          end
        end
        RELU:    next_state = DONE;
        default: next_state = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done     <= 1'b0;
      pass_cnt <= '0;
    end else begin
      done <= (next_state == DONE) && (state != DONE);
      if (start) begin
        pass_cnt <= '0;
      end else if (pass_end) begin
        pass_cnt <= pass_cnt + PCW'(1);
      end
    end
  end

  // Only the addressed row is written per beat, so one adder per lane suffices.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int l = 0; l < COL; l++) begin
          bank[r][l] <= '0;
        end
      end
    end else if (start) begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int l = 0; l < COL; l++) begin
          bank[r][l] <= '0;
        end
      end
    end else if (accept) begin
      for (int l = 0; l < COL; l++) begin
        bank[in_if.in_addr][l] <= sum_row[l];
      end
    end
`ifdef SFU_RELU_EN
    else if (state == RELU) begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int l = 0; l < COL; l++) begin
          bank[r][l] <= relu_clamp(bank[r][l]);
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      for (int l = 0; l < COL; l++) begin
        rd_data[l*PSUM_BW +: PSUM_BW] <= bank[rd_addr][l];
      end
    end
  end

endmodule

// File: tb/tb_sfu_accum.sv
// Randomized and directed bench for sfu_accum against an integer reference model.
module tb_sfu_accum;
  import sfu_pkg::*;

  localparam int W = COL * PSUM_BW;
`ifdef SFU_RELU_EN
  localparam bit RELU_ON = 1'b1;
`else
  localparam bit RELU_ON = 1'b0;
`endif

  logic           clk     = 1'b0;
  logic           reset   = 1'b0;
  logic           start   = 1'b0;
  logic [AW-1:0]  rd_addr = '0;
  logic           busy;
  logic           done;
  logic [W-1:0]   rd_data;
  logic [PCW-1:0] pass_cnt;

  sfu_accum_if bus ();

  sfu_accum dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_if    (bus),
    .busy     (busy),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .pass_cnt (pass_cnt)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_ACC, M_RELU, M_DONE} mphase_t;

  int           mbank [DEPTH][COL];
  int           mpasses   = 0;
  mphase_t      mphase    = M_IDLE;
  logic [W-1:0] exp_rd    = '0;
  logic         exp_done  = 1'b0;
  int           n_checks  = 0;
  int           n_pass    = 0;

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [W-1:0] row_word(input int r);
    logic [W-1:0] w;
    for (int l = 0; l < COL; l++) w[l*PSUM_BW +: PSUM_BW] = 16'(mbank[r][l]);
    return w;
  endfunction

  function automatic logic [W-1:0] splat(input logic [15:0] v);
    logic [W-1:0] w;
    for (int l = 0; l < COL; l++) w[l*PSUM_BW +: PSUM_BW] = v;
    return w;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < DEPTH; r++)
      for (int l = 0; l < COL; l++) mbank[r][l] = 0;
    mpasses = 0;
  endtask

  // Reference behaviour: what every clock edge must do to the bank and counters.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      clear_model();
      mphase   = M_IDLE;
      exp_rd   = '0;
      exp_done = 1'b0;
    end else begin
      exp_rd   = row_word(int'(rd_addr));
      exp_done = 1'b0;
      if (start) begin
        clear_model();
        mphase = M_ACC;
      end else if (mphase == M_ACC && bus.in_valid) begin
        for (int l = 0; l < COL; l++)
          mbank[bus.in_addr][l] = sat(mbank[bus.in_addr][l] +
                                      int'($signed(bus.in_psum[l*PSUM_BW +: PSUM_BW])));
        if (int'(bus.in_addr) == DEPTH - 1) begin
          mpasses++;
          if (mpasses == NUM_PASS) begin
            if (RELU_ON) mphase = M_RELU;
            else begin
              mphase   = M_DONE;
              exp_done = 1'b1;
            end
          end
        end
      end else if (mphase == M_RELU) begin
        for (int r = 0; r < DEPTH; r++)
          for (int l = 0; l < COL; l++)
            if (mbank[r][l] < 0) mbank[r][l] = 0;
        mphase   = M_DONE;
        exp_done = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s actual=%b expected=%b", name, actual, expected);
  endtask

  // Every cycle out of reset, the DUT outputs must match the model.
  initial forever begin
    @(negedge clk);
    if (reset === 1'b1) begin
      checkOutput("rd_data", rd_data, exp_rd);
      checkOutput("pass_cnt", W'(pass_cnt), W'(mpasses));
      check_bit("busy", busy, mphase == M_ACC || mphase == M_RELU);
      check_bit("done", done, exp_done);
      check_bit("in_ready", bus.in_ready, mphase == M_ACC && !start);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [W-1:0] p);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_psum  = p;
    rd_addr      = AW'($urandom);
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int l = 0; l < COL; l++) begin
      int x = int'($urandom_range(0, 8000)) - 4000;
      w[l*PSUM_BW +: PSUM_BW] = x[15:0];
    end
    return w;
  endfunction

  task automatic run_passes(input int val, input bit reverse, input bit rnd, input bit gaps);
    for (int p = 0; p < NUM_PASS; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (gaps && $urandom_range(0, 3) == 0) applyStimulus(1'b0, '0, '0);
        applyStimulus(1'b1, AW'(reverse ? DEPTH - 1 - i : i), rnd ? rand_word() : splat(val[15:0]));
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check_bit("done_seen", done, 1'b1);
  endtask

  task automatic read_row(input int r, output logic [W-1:0] d);
    rd_addr = AW'(r);
    tick();
    d = rd_data;
  endtask

  initial begin
    logic [W-1:0] d;
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] d;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_psum  = '0;
    repeat (3) tick();
    checkOutput("reset_rd_data", rd_data, '0);
    checkOutput("reset_pass_cnt", W'(pass_cnt), '0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_in_ready", bus.in_ready, 1'b0);
    reset = 1'b1;
    tick();

    // Nine passes of +1 per lane
    pulse_start();
    run_passes(1, 1'b0, 1'b0, 1'b1);
    wait_done();
    checkOutput("t1_pass_cnt", W'(pass_cnt), W'(9));
    read_row(7, d);
    checkOutput("t1_row7", d, splat(16'd9));
    read_row(0, d);
    checkOutput("t1_row0", d, splat(16'd9));

    // Nine passes of -3 per lane
    pulse_start();
    run_passes(-3, 1'b0, 1'b0, 1'b0);
    wait_done();
    read_row(3, d);
    checkOutput("t2_row3", d, RELU_ON ? splat(16'h0000) : splat(16'hFFE5));

    // Saturation at both ends on row 5
    pulse_start();
    d = '0;
    d[15:0]  = 16'h7FF0;
    d[31:16] = 16'h8010;
    applyStimulus(1'b1, AW'(5), d);
    d[15:0]  = 16'h0100;
    d[31:16] = 16'hFF00;
    applyStimulus(1'b1, AW'(5), d);
    bus.in_valid = 1'b0;
    read_row(5, d);
    checkOutput("t3_pos_clamp", W'(d[15:0]), W'(16'h7FFF));
    checkOutput("t3_neg_clamp", W'(d[31:16]), W'(16'h8000));

    // start and in_valid together: beat dropped, bank cleared
    start        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_addr  = AW'(2);
    bus.in_psum  = splat(16'd1);
    #1;
    check_bit("t4_in_ready", bus.in_ready, 1'b0);
    tick();
    start        = 1'b0;
    bus.in_valid = 1'b0;
    read_row(5, d);
    checkOutput("t4_row5_clear", d, '0);
    read_row(2, d);
    checkOutput("t4_row2_dropped", d, '0);

    // Reset in the middle of pass 4, then a clean run
    pulse_start();
    for (int i = 0; i < 3 * DEPTH + 5; i++) applyStimulus(1'b1, AW'(i % DEPTH), splat(16'd1));
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checkOutput("t5_rd_data", rd_data, '0);
    checkOutput("t5_pass_cnt", W'(pass_cnt), '0);
    check_bit("t5_busy", busy, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    pulse_start();
    run_passes(1, 1'b0, 1'b0, 1'b0);
    wait_done();
    read_row(11, d);
    checkOutput("t5_row11", d, splat(16'd9));

    // Reverse row order with random values
    pulse_start();
    applyStimulus(1'b1, AW'(15), splat(16'd2));
    checkOutput("t6_first_pass", W'(pass_cnt), W'(1));
    run_passes(0, 1'b1, 1'b1, 1'b1);
    for (int r = 0; r < DEPTH; r++) read_row(r, d);

    // Free-running random traffic with occasional restarts
    for (int round = 0; round < 2; round++) begin
      pulse_start();
      for (int c = 0; c < 700; c++) begin
        start = ($urandom_range(0, 299) == 0);
        applyStimulus(1'($urandom_range(0, 3) != 0), AW'($urandom), rand_word());
        start = 1'b0;
      end
      bus.in_valid = 1'b0;
      for (int r = 0; r < DEPTH; r++) read_row(r, d);
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
